servo_pwm_multi: RTL and testbench

- N-channel hobby-servo PWM generator; successor to the single-channel fixed-position servo driver.
- One shared frame counter; per-channel programmable pulse width, clamped to a safe range.
- Widths are shadow-registered and applied only at frame boundaries, so pulses never glitch.
- Sits behind the SoC register bank (CSR write strobe) and drives servo pins directly.

---
 rtl/servo_pwm_pkg.sv | 23 ++
 rtl/servo_pwm_ch.sv | 68 ++++++
 rtl/servo_pwm_multi.sv | 82 ++++++++
 tb/tb_servo_pwm_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_pkg.sv
// Shared defaults, width type and clamp helper for the servo_pwm_multi block.
// SERVO_PWM_SLEW_EN (optional) limits how far a channel width moves per frame.
package servo_pwm_pkg;

    localparam int unsigned CNT_W_DEF      = 21;
    localparam int unsigned PERIOD_CYC_DEF = 1_000_000;
    localparam int unsigned MIN_CYC_DEF    = 50_000;
    localparam int unsigned MAX_CYC_DEF    = 250_000;
    localparam int unsigned RST_CYC_DEF    = 150_000;
    localparam int unsigned SLEW_STEP_DEF  = 2_000;

    typedef logic [CNT_W_DEF-1:0] width_t;

    // Saturate a requested width into the safe [lo, hi] servo range.
    function automatic int unsigned clamp_width(input int unsigned w,
                                                input int unsigned lo,
                                                input int unsigned hi);
        if (w < lo) return lo;
        if (w > hi) return hi;
        return w;
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: clamped target, frame-synchronous active width and output compare.
// SERVO_PWM_SLEW_EN bounds the per-frame change of the active width.
module servo_pwm_ch
    import servo_pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned MIN_CYC = MIN_CYC_DEF,
    parameter int unsigned MAX_CYC = MAX_CYC_DEF,
    parameter int unsigned RST_CYC = RST_CYC_DEF
`ifdef SERVO_PWM_SLEW_EN
    ,
    parameter int unsigned SLEW_STEP = SLEW_STEP_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_width,
    input  logic [CNT_W-1:0] cnt,
    input  logic             boundary,
    input  logic             en,
    output logic             servo
);

    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] next_target;
    logic             servo_q, servo_d;

    // A write landing on the boundary edge must reach the new frame directly.
    always_comb begin
        next_target = target_q;
        if (wr_hit) begin
            next_target = CNT_W'(clamp_width(32'(wr_width), MIN_CYC, MAX_CYC));
        end
        target_d = next_target;
        active_d = active_q;
        if (boundary) begin
`ifdef SERVO_PWM_SLEW_EN
            if (next_target > active_q) begin
                active_d = ((next_target - active_q) <= CNT_W'(SLEW_STEP))
                         ? next_target : active_q + CNT_W'(SLEW_STEP);
            end else begin
                active_d = ((active_q - next_target) <= CNT_W'(SLEW_STEP))
                         ? next_target : active_q - CNT_W'(SLEW_STEP);
            end
`else
            active_d = next_target;
`endif
        end
        servo_d = en & (cnt < active_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= CNT_W'(RST_CYC);
            active_q <= CNT_W'(RST_CYC);
            servo_q  <= 1'b0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            servo_q  <= servo_d;
        end
    end

    assign servo = servo_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel hobby-servo PWM generator with a shared frame counter and CSR write port.
// Define SERVO_PWM_SLEW_EN to rate-limit width changes per frame.
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned PERIOD_CYC = PERIOD_CYC_DEF,
    parameter int unsigned MIN_CYC    = MIN_CYC_DEF,
    parameter int unsigned MAX_CYC    = MAX_CYC_DEF,
    parameter int unsigned RST_CYC    = RST_CYC_DEF,
    parameter int unsigned SLEW_STEP  = SLEW_STEP_DEF,
    parameter int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_width,
    input  logic [N_CH-1:0]  ch_en,
    output logic [N_CH-1:0]  servo,
    output logic             frame_start
);

    localparam int unsigned CH_W_MIN = (N_CH > 1) ? $clog2(N_CH) : 1;

    // The clamp helper works on 32-bit values, hence the CNT_W ceiling.
    if (N_CH < 1 || N_CH > 16 || CH_W < CH_W_MIN || CNT_W > 32 ||
        MIN_CYC > RST_CYC || RST_CYC > MAX_CYC || MAX_CYC >= PERIOD_CYC ||
        64'(PERIOD_CYC) >= (64'd1 << CNT_W) || SLEW_STEP == 0) begin : g_bad_cfg
        $error("servo_pwm_multi: invalid parameter set");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_start_q, frame_start_d;
    logic             boundary_c;

    always_comb begin
        boundary_c    = (cnt_q == CNT_W'(PERIOD_CYC - 1));
        cnt_d         = boundary_c ? '0 : cnt_q + CNT_W'(1);
        frame_start_d = (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

    // Out-of-range channel indices match no instance and are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_hit_c;
        assign wr_hit_c = wr_en && (wr_ch == CH_W'(i));

        servo_pwm_ch #(
            .CNT_W    (CNT_W),
            .MIN_CYC  (MIN_CYC),
            .MAX_CYC  (MAX_CYC),
            .RST_CYC  (RST_CYC)
`ifdef SERVO_PWM_SLEW_EN
            ,
            .SLEW_STEP(SLEW_STEP)
`endif
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_hit  (wr_hit_c),
            .wr_width(wr_width),
            .cnt     (cnt_q),
            .boundary(boundary_c),
            .en      (ch_en[i]),
            .servo   (servo[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: directed frames plus random writes/enables
// compared cycle by cycle against a frame-level behavioural model.
module tb_servo_pwm_multi;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 11;
    localparam int CH_W   = 3;
    localparam int PERIOD = 1000;
    localparam int MINW   = 50;
    localparam int MAXW   = 240;
    localparam int RSTW   = 150;
    localparam int SLEW   = 20;
`ifdef SERVO_PWM_SLEW_EN
    localparam int STEP   = SLEW;
    localparam bit SLEW_ON = 1'b1;
`else
    localparam int STEP   = PERIOD;
    localparam bit SLEW_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_width;
    logic [N_CH-1:0]  ch_en;
    logic [N_CH-1:0]  servo;
    logic             frame_start;

    servo_pwm_multi #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .PERIOD_CYC(PERIOD),
        .MIN_CYC   (MINW),
        .MAX_CYC   (MAXW),
        .RST_CYC   (RSTW),
        .SLEW_STEP (SLEW),
        .CH_W      (CH_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_width   (wr_width),
        .ch_en      (ch_en),
        .servo      (servo),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int m_cnt;
    int m_target[N_CH];
    int m_active[N_CH];
    int hc[N_CH];
    int snap[N_CH];

    function automatic int clampw(input int w);
        if (w < MINW) return MINW;
        if (w > MAXW) return MAXW;
        return w;
    endfunction

    // Width applied at a frame boundary: move toward the target by at most STEP.
    function automatic int shadow(input int act, input int tgt);
        if (tgt - act > STEP) return act + STEP;
        if (act - tgt > STEP) return act - STEP;
        return tgt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from the current model state, advance the model, compare.
    task automatic tick();
        logic [N_CH-1:0] exp_s;
        logic            exp_f;
        int              cnt_now;
        exp_s   = '0;
        exp_f   = 1'b0;
        cnt_now = m_cnt;
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) exp_s[i] = ch_en[i] && (m_cnt < m_active[i]);
            exp_f = (m_cnt == 0);
        end
        if (rst) begin
            m_cnt = 0;
            for (int i = 0; i < N_CH; i++) begin
                m_target[i] = RSTW;
                m_active[i] = RSTW;
            end
        end else begin
            if (wr_en && int'(wr_ch) < N_CH) m_target[int'(wr_ch)] = clampw(int'(wr_width));
            if (m_cnt == PERIOD - 1) begin
                m_cnt = 0;
                for (int i = 0; i < N_CH; i++) m_active[i] = shadow(m_active[i], m_target[i]);
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        check($sformatf("servo@cnt%0d", cnt_now), 32'(servo), 32'(exp_s));
        check($sformatf("frame_start@cnt%0d", cnt_now), 32'(frame_start), 32'(exp_f));
        for (int i = 0; i < N_CH; i++) hc[i] += int'(servo[i]);
    endtask

    // One full frame from cnt==0 with an optional single write; widths checked against the model.
    task automatic run_frame(input int wcnt, input int wch, input int wval);
        for (int i = 0; i < N_CH; i++) begin
            hc[i]   = 0;
            snap[i] = m_active[i];
        end
        for (int c = 0; c < PERIOD; c++) begin
            if (c == wcnt) begin
                wr_en    = 1'b1;
                wr_ch    = CH_W'(wch);
                wr_width = CNT_W'(wval);
            end
            tick();
        end
        for (int i = 0; i < N_CH; i++) check($sformatf("width_ch%0d", i), 32'(hc[i]), 32'(snap[i]));
    endtask

    task automatic run_to(input int c);
        for (int k = 0; k < PERIOD && m_cnt != c; k++) tick();
    endtask

    initial begin
        int slew_seq[5];
        int idx;
        slew_seq = '{170, 190, 210, 230, 240};
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_width = '0;
        ch_en    = '0;
        m_cnt    = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_target[i] = RSTW;
            m_active[i] = RSTW;
            hc[i]       = 0;
        end
        repeat (3) tick();
        rst   = 1'b0;
        ch_en = 4'hF;

        run_frame(-1, 0, 0);
        for (int i = 0; i < N_CH; i++) check($sformatf("reset_width_ch%0d", i), 32'(hc[i]), 32'(RSTW));

        run_frame(300, 2, 200);
        check("ch2_hold", 32'(hc[2]), 32'(RSTW));
        run_frame(500, 1, 10);
        check("ch2_new", 32'(hc[2]), SLEW_ON ? 32'd170 : 32'd200);
        run_frame(500, 1, 900);
        check("ch1_min", 32'(hc[1]), SLEW_ON ? 32'd130 : 32'd50);
        run_frame(10, 5, 77);
        check("ch1_max", 32'(hc[1]), SLEW_ON ? 32'd150 : 32'd240);
        run_frame(999, 0, 100);
        check("ch0_before_edge_write", 32'(hc[0]), 32'(RSTW));
        check("ch3_bad_index", 32'(hc[3]), 32'(RSTW));
        check("ch1_bad_index", 32'(hc[1]), SLEW_ON ? 32'd170 : 32'd240);
        run_frame(-1, 0, 0);
        check("ch0_edge_write", 32'(hc[0]), SLEW_ON ? 32'd130 : 32'd100);

        // ch_en[3] dropped for cnt 80..119 removes exactly 40 high cycles.
        for (int i = 0; i < N_CH; i++) hc[i] = 0;
        for (int c = 0; c < PERIOD; c++) begin
            if (c == 80)  ch_en[3] = 1'b0;
            if (c == 120) ch_en[3] = 1'b1;
            tick();
        end
        check("ch3_enable_gap", 32'(hc[3]), 32'(RSTW - 40));

        run_to(70);
        rst = 1'b1;
        tick();
        check("rst_mid_frame", 32'(servo), 32'd0);
        rst = 1'b0;

        run_frame(500, 0, 240);
        for (int i = 0; i < N_CH; i++) check($sformatf("post_rst_width_ch%0d", i), 32'(hc[i]), 32'(RSTW));
        for (int f = 0; f < 5; f++) begin
            run_frame(-1, 0, 0);
            check($sformatf("slew_frame%0d", f), 32'(hc[0]), SLEW_ON ? 32'(slew_seq[f]) : 32'd240);
        end

        for (int k = 0; k < 8000; k++) begin
            if (($urandom_range(0, 39) == 0) || ((m_cnt == PERIOD - 1) && ($urandom_range(0, 1) == 0))) begin
                wr_en    = 1'b1;
                wr_ch    = CH_W'($urandom_range(0, 7));
                wr_width = CNT_W'($urandom_range(0, 2047));
            end
            if ($urandom_range(0, 199) == 0) begin
                idx        = int'($urandom_range(0, N_CH - 1));
                ch_en[idx] = ~ch_en[idx];
            end
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
